// File: rtl/button_press_gen.sv
// rtl/button_press_gen.sv - synthetic bouncy push-button waveform generator
// One start pulse yields press chatter, a stable hold, release chatter, then a done pulse.
module button_press_gen #(
   parameter int          HOLD_W    = 16,
   parameter int          GAP_W     = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [HOLD_W-1:0] i_hold_cycles,
   input  logic              i_bounce_en,
   input  logic [3:0]        i_bounce_cnt,
   output logic              o_btn_out,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

   typedef enum logic [1:0] {S_IDLE, S_PRESS_BNC, S_HOLD, S_REL_BNC} state_t;

   state_t            r_state, w_state_nx;
   logic              r_btn, w_btn_nx;
   logic              r_busy, w_busy_nx;
   logic              r_done, w_done_nx;
   logic [15:0]       r_lfsr;
   logic [HOLD_W-1:0] r_h, w_h_nx;
   logic [HOLD_W-1:0] r_hold, w_hold_nx;
   logic [GAP_W-1:0]  r_gap, w_gap_nx;
   logic [4:0]        r_tog, w_tog_nx;
   logic [4:0]        r_n2, w_n2_nx;

   logic [GAP_W-1:0]  w_gap;
   logic [HOLD_W-1:0] w_hold_in;
   logic [4:0]        w_n2_in;
   logic              w_fb;

   // A zero gap or zero hold would stall the counters, so both are clamped to 1.
   assign w_gap     = (r_lfsr[GAP_W-1:0] == '0) ? GAP_W'(1) : r_lfsr[GAP_W-1:0];
   assign w_hold_in = (i_hold_cycles == '0) ? HOLD_W'(1) : i_hold_cycles;
   assign w_n2_in   = i_bounce_en ? {i_bounce_cnt, 1'b0} : 5'd0;
   assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_btn   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_lfsr  <= SEED;
         r_h     <= '0;
         r_hold  <= '0;
         r_gap   <= '0;
         r_tog   <= '0;
         r_n2    <= '0;
      end else begin
         r_state <= w_state_nx;
         r_btn   <= w_btn_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
         r_lfsr  <= {r_lfsr[14:0], w_fb};
         r_h     <= w_h_nx;
         r_hold  <= w_hold_nx;
         r_gap   <= w_gap_nx;
         r_tog   <= w_tog_nx;
         r_n2    <= w_n2_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_btn_nx   = r_btn;
      w_busy_nx  = r_busy;
      w_done_nx  = 1'b0;
      w_h_nx     = r_h;
      w_hold_nx  = r_hold;
      w_gap_nx   = r_gap;
      w_tog_nx   = r_tog;
      w_n2_nx    = r_n2;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_btn_nx  = 1'b1;
               w_busy_nx = 1'b1;
               w_h_nx    = w_hold_in;
               w_n2_nx   = w_n2_in;
               w_tog_nx  = '0;
               w_gap_nx  = w_gap;
               w_hold_nx = w_hold_in;
               w_state_nx = (w_n2_in == 5'd0) ? S_HOLD : S_PRESS_BNC;
            end
         end
         S_PRESS_BNC: begin
            if (r_gap == GAP_W'(1)) begin
               w_btn_nx = ~r_btn;
               w_tog_nx = r_tog + 5'd1;
               w_gap_nx = w_gap;
               if ((r_tog + 5'd1) == r_n2) begin
                  w_hold_nx  = r_h;
                  w_state_nx = S_HOLD;
               end
            end else begin
               w_gap_nx = r_gap - GAP_W'(1);
            end
         end
         S_HOLD: begin
            if (r_hold == HOLD_W'(1)) begin
               w_btn_nx = 1'b0;
               if (r_n2 == 5'd0) begin
                  w_busy_nx  = 1'b0;
                  w_done_nx  = 1'b1;
                  w_state_nx = S_IDLE;
               end else begin
                  w_tog_nx   = '0;
                  w_gap_nx   = w_gap;
                  w_state_nx = S_REL_BNC;
               end
            end else begin
               w_hold_nx = r_hold - HOLD_W'(1);
            end
         end
         S_REL_BNC: begin
            // After the last release toggle the low level is held one extra cycle.
            if (r_tog == r_n2) begin
               w_btn_nx   = 1'b0;
               w_busy_nx  = 1'b0;
               w_done_nx  = 1'b1;
               w_state_nx = S_IDLE;
            end else if (r_gap == GAP_W'(1)) begin
               w_btn_nx = ~r_btn;
               w_tog_nx = r_tog + 5'd1;
               w_gap_nx = w_gap;
            end else begin
               w_gap_nx = r_gap - GAP_W'(1);
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign o_btn_out = r_btn;
   assign o_busy    = r_busy;
   assign o_done    = r_done;

endmodule
